// File: rtl/lcd_hd44780_responder_if.sv
`timescale 1ns/1ps
// 8-bit HD44780 pin bundle: initiator drives DATA/RS/RW/EN,
// responder returns read data and its output-enable.
interface lcd_hd44780_responder_if;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_data_in,
    output lcd_rs,
    output lcd_rw,
    output lcd_en,
    input  lcd_data_out,
    input  lcd_data_oe
  );

  modport slave (
    input  lcd_data_in,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_en,
    output lcd_data_out,
    output lcd_data_oe
  );
endinterface

// File: rtl/lcd_hd44780_responder.sv
`timescale 1ns/1ps
// HD44780 bus responder: shadows a 2x16 DDRAM and controller state,
// models the busy flag and answers status/data reads.
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 80000
) (
  input  logic        clock,
  input  logic        reset_n,
  lcd_hd44780_responder_if.slave bus,
  input  logic [4:0]  char_addr,
  output logic [7:0]  char_out,
  output logic        display_on,
  output logic        busy,
  output logic        overrun,
  output logic        addr_err,
  output logic [15:0] write_count
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_BUSY
  } state_e;

  localparam int unsigned CLR_TAIL = CLEAR_CYCLES - 32;

  logic [7:0] d_s1_q, d_s2_q, d_p_q;
  logic       rs_s1_q, rs_s2_q, rs_p_q;
  logic       rw_s1_q, rw_s2_q, rw_p_q;
  logic       en_s1_q, en_s2_q, en_p_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_s1_q  <= '0;
      d_s2_q  <= '0;
      d_p_q   <= '0;
      rs_s1_q <= 1'b0;
      rs_s2_q <= 1'b0;
      rs_p_q  <= 1'b0;
      rw_s1_q <= 1'b0;
      rw_s2_q <= 1'b0;
      rw_p_q  <= 1'b0;
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      en_p_q  <= 1'b0;
    end else begin
      d_s1_q  <= bus.lcd_data_in;
      d_s2_q  <= d_s1_q;
      d_p_q   <= d_s2_q;
      rs_s1_q <= bus.lcd_rs;
      rs_s2_q <= rs_s1_q;
      rs_p_q  <= rs_s2_q;
      rw_s1_q <= bus.lcd_rw;
      rw_s2_q <= rw_s1_q;
      rw_p_q  <= rw_s2_q;
      en_s1_q <= bus.lcd_en;
      en_s2_q <= en_s1_q;
      en_p_q  <= en_s2_q;
    end
  end

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  wipe_q, wipe_d;
  logic        wipe_en;

  logic [4:0]  idx_q, idx_d;
  logic        inc_q, inc_d;
  logic        disp_q, disp_d;
  logic        ovr_q, ovr_d;
  logic        aerr_q, aerr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  mem_q [32];
  logic [6:0]  addr;

  logic fall, wr_acc, wr_drop, cmd_acc, dat_acc, rd_step;
  logic is_clr, is_home, is_ems, is_dc, is_set;

  // rs/rw/data come from the sample taken alongside the last EN-high one
  assign fall    = en_p_q & ~en_s2_q;
  assign wr_acc  = fall & ~rw_p_q & ~busy;
  assign wr_drop = fall & ~rw_p_q & busy;
  assign cmd_acc = wr_acc & ~rs_p_q;
  assign dat_acc = wr_acc & rs_p_q;
  assign rd_step = fall & rw_p_q & rs_p_q & ~busy;

  assign is_clr  = (d_p_q == 8'h01);
  assign is_home = (d_p_q[7:1] == 7'h01);
  assign is_ems  = (d_p_q[7:2] == 6'h01);
  assign is_dc   = (d_p_q[7:3] == 5'h01);
  assign is_set  = d_p_q[7];

  assign addr = {idx_q[4], 2'b00, idx_q[3:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wipe_q  <= wipe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wipe_d  = wipe_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          if (cmd_acc && is_clr) begin
            state_d = S_CLEAR;
            wipe_d  = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = (cmd_acc && is_home) ? CLEAR_CYCLES : BUSY_CYCLES;
          end
        end
      end
      S_CLEAR: begin
        wipe_d = wipe_q + 5'd1;
        if (wipe_q == 5'd31) begin
          state_d = S_BUSY;
          cnt_d   = CLR_TAIL;
        end
      end
      S_BUSY: begin
        if (cnt_q <= 32'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    wipe_en = (state_q == S_CLEAR);
  end

  always_comb begin
    idx_d  = idx_q;
    inc_d  = inc_q;
    disp_d = disp_q;
    ovr_d  = ovr_q | wr_drop;
    aerr_d = aerr_q;
    wcnt_d = wcnt_q;
    if (dat_acc && wcnt_q != 16'hFFFF) begin
      wcnt_d = wcnt_q + 16'd1;
    end
    // linear 5-bit index wraps 15->16 (0x0F->0x40) and 31->0
    if (dat_acc || rd_step) begin
      idx_d = inc_q ? idx_q + 5'd1 : idx_q - 5'd1;
    end
    if (cmd_acc) begin
      unique case (1'b1)
        is_clr: begin
          idx_d = '0;
          inc_d = 1'b1;
        end
        is_home: idx_d = '0;
        is_ems:  inc_d = d_p_q[1];
        is_dc:   disp_d = d_p_q[2];
        is_set: begin
          if (d_p_q[5:4] == 2'b00) begin
            idx_d = {d_p_q[6], d_p_q[3:0]};
          end else begin
            aerr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      inc_q  <= 1'b1;
      disp_q <= 1'b0;
      ovr_q  <= 1'b0;
      aerr_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      idx_q  <= idx_d;
      inc_q  <= inc_d;
      disp_q <= disp_d;
      ovr_q  <= ovr_d;
      aerr_q <= aerr_d;
      wcnt_q <= wcnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 8'h20;
      end
    end else if (wipe_en) begin
      mem_q[wipe_q] <= 8'h20;
    end else if (dat_acc) begin
      mem_q[idx_q] <= d_p_q;
    end
  end

  assign bus.lcd_data_oe  = en_s2_q & rw_s2_q;
  assign bus.lcd_data_out = !bus.lcd_data_oe ? 8'h00 :
                            rs_s2_q ? mem_q[idx_q] : {busy, addr};

  assign char_out    = mem_q[char_addr];
  assign display_on  = disp_q;
  assign overrun     = ovr_q;
  assign addr_err    = aerr_q;
  assign write_count = wcnt_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
`timescale 1ns/1ps
// Directed bench for lcd_hd44780_responder: a display model tracks
// DDRAM/flags/busy time and is compared on every falling clock edge.
module tb_lcd_hd44780_responder;
  localparam int BUSY_N  = 20;
  localparam int CLEAR_N = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  char_addr = '0;
  logic [7:0]  char_out;
  logic        display_on, busy, overrun, addr_err;
  logic [15:0] write_count;

  lcd_hd44780_responder_if bus_if();

  lcd_hd44780_responder #(
    .BUSY_CYCLES (BUSY_N),
    .CLEAR_CYCLES(CLEAR_N)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .bus        (bus_if),
    .char_addr  (char_addr),
    .char_out   (char_out),
    .display_on (display_on),
    .busy       (busy),
    .overrun    (overrun),
    .addr_err   (addr_err),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  byte unsigned m_mem [32];
  byte unsigned m_old [32];
  int m_addr, m_inc, m_disp, m_ovr, m_aerr, m_wc;
  int busy_end, clr_start;
  bit in_read = 1'b0;
  byte unsigned v;
  int n;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, ncyc);
    end
  endtask

  function automatic int a2i(int a);
    return (a >= 'h40) ? 16 + (a - 'h40) : a;
  endfunction

  function automatic int step(int a, int inc);
    if (inc != 0) begin
      if (a == 'h0F) return 'h40;
      if (a == 'h4F) return 'h00;
      return a + 1;
    end
    if (a == 'h00) return 'h4F;
    if (a == 'h40) return 'h0F;
    return a - 1;
  endfunction

  // cell i is wiped on the (i+1)-th edge after the clear commits
  function automatic int exp_cell(int i);
    return (ncyc < clr_start + 1 + i) ? int'(m_old[i]) : int'(m_mem[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 8'h20;
      m_old[i] = 8'h20;
    end
    m_addr = 0; m_inc = 1; m_disp = 0;
    m_ovr = 0; m_aerr = 0; m_wc = 0;
    busy_end = 0; clr_start = -100;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      chk("char_out", char_out, exp_cell(char_addr));
      chk("busy", busy, int'(ncyc < busy_end));
      chk("display_on", display_on, m_disp);
      chk("overrun", overrun, m_ovr);
      chk("addr_err", addr_err, m_aerr);
      chk("write_count", write_count, m_wc);
      if (!in_read) begin
        chk("oe_idle", bus_if.lcd_data_oe, 0);
        chk("dout_idle", bus_if.lcd_data_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    char_addr = char_addr + 5'd1;
  endtask

  task automatic lcd_write(bit rs, byte unsigned d);
    int k;
    bus_if.lcd_rs = rs;
    bus_if.lcd_rw = 1'b0;
    bus_if.lcd_data_in = d;
    tick();
    bus_if.lcd_en = 1'b1;
    repeat (3) tick();
    bus_if.lcd_en = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    k = ncyc + 1;
    if (ncyc < busy_end) begin
      m_ovr = 1;
    end else if (rs) begin
      m_mem[a2i(m_addr)] = d;
      m_addr = step(m_addr, m_inc);
      if (m_wc < 65535) m_wc++;
      busy_end = k + BUSY_N;
    end else begin
      busy_end = k + BUSY_N;
      if (d == 8'h01) begin
        m_old = m_mem;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        clr_start = k;
        m_addr = 0;
        m_inc = 1;
        busy_end = k + CLEAR_N;
      end else if (d == 8'h02 || d == 8'h03) begin
        m_addr = 0;
        busy_end = k + CLEAR_N;
      end else if (d >= 8'h04 && d <= 8'h07) begin
        m_inc = (d / 2) % 2;
      end else if (d >= 8'h08 && d <= 8'h0F) begin
        m_disp = (d / 4) % 2;
      end else if (d >= 8'h80) begin
        if ((d - 128) <= 'h0F || ((d - 128) >= 'h40 && (d - 128) <= 'h4F))
          m_addr = d - 128;
        else
          m_aerr = 1;
      end
    end
    #1;
    char_addr = char_addr + 5'd1;
  endtask

  task automatic lcd_read(bit rs, output byte unsigned val);
    int expv;
    in_read = 1'b1;
    bus_if.lcd_rs = rs;
    bus_if.lcd_rw = 1'b1;
    tick();
    bus_if.lcd_en = 1'b1;
    repeat (3) tick();
    if (rs) expv = m_mem[a2i(m_addr)];
    else expv = ((ncyc + 1 < busy_end) ? 128 : 0) + m_addr;
    chk("rd_oe", bus_if.lcd_data_oe, 1);
    chk("rd_data", bus_if.lcd_data_out, expv);
    val = bus_if.lcd_data_out;
    bus_if.lcd_en = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    if (rs && !(ncyc < busy_end)) m_addr = step(m_addr, m_inc);
    #1;
    char_addr = char_addr + 5'd1;
    in_read = 1'b0;
    bus_if.lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < CLEAR_N + 50) begin
      tick();
      k++;
    end
    chk("wait_idle_timeout", busy, 0);
    tick();
  endtask

  task automatic expect_cell(int i, int val, string nm);
    tick();
    char_addr = i[4:0];
    #1;
    chk(nm, char_out, val);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    in_read = 1'b0;
    bus_if.lcd_en = 1'b0;
    bus_if.lcd_rs = 1'b0;
    bus_if.lcd_rw = 1'b0;
    bus_if.lcd_data_in = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.lcd_en = 1'b0;
    bus_if.lcd_rs = 1'b0;
    bus_if.lcd_rw = 1'b0;
    bus_if.lcd_data_in = 8'h00;
    model_reset();
    do_reset();

    for (int i = 0; i < 32; i++) expect_cell(i, 8'h20, "reset_cell");
    chk("reset_busy", busy, 0);
    lcd_read(1'b0, v);
    chk("reset_status", v, 8'h00);

    lcd_write(1'b0, 8'h0C); wait_idle();
    lcd_write(1'b1, 8'h48); wait_idle();
    lcd_write(1'b1, 8'h69); wait_idle();
    expect_cell(0, 8'h48, "cell_H");
    expect_cell(1, 8'h69, "cell_i");
    chk("disp_on_lit", display_on, 1);
    chk("wcount_2", write_count, 2);

    lcd_write(1'b0, 8'hC0); wait_idle();
    lcd_write(1'b1, 8'h41); wait_idle();
    expect_cell(16, 8'h41, "cell_A");
    lcd_read(1'b0, v);
    chk("status_41", v, 8'h41);

    lcd_write(1'b0, 8'h8F); wait_idle();
    lcd_write(1'b1, 8'h78); wait_idle();
    lcd_write(1'b1, 8'h79); wait_idle();
    expect_cell(15, 8'h78, "cell_x_wrap");
    expect_cell(16, 8'h79, "cell_y_wrap");

    lcd_write(1'b0, 8'h04); wait_idle();
    lcd_write(1'b0, 8'h80); wait_idle();
    lcd_write(1'b1, 8'h77); wait_idle();
    lcd_write(1'b1, 8'h7A); wait_idle();
    expect_cell(0, 8'h77, "cell_w_dec");
    expect_cell(31, 8'h7A, "cell_z_dec");
    lcd_read(1'b0, v);
    chk("status_4e", v, 8'h4E);

    lcd_write(1'b0, 8'h06); wait_idle();
    lcd_write(1'b0, 8'h80);
    lcd_read(1'b0, v);
    chk("status_busy", v, 8'h80);
    lcd_read(1'b1, v);
    wait_idle();
    lcd_read(1'b0, v);
    chk("busy_read_no_step", v, 8'h00);
    lcd_read(1'b1, v);
    chk("data_read", v, 8'h77);
    lcd_read(1'b0, v);
    chk("read_step", v, 8'h01);

    lcd_write(1'b0, 8'h01);
    n = 0;
    while (busy && n < CLEAR_N + 20) begin
      tick();
      n++;
    end
    chk("clear_busy_len", n, 40);
    for (int i = 0; i < 32; i++) expect_cell(i, 8'h20, "cleared_cell");

    lcd_write(1'b0, 8'h01);
    lcd_write(1'b1, 8'h51);
    chk("overrun_lit", overrun, 1);
    wait_idle();
    expect_cell(0, 8'h20, "overrun_no_write");
    chk("wcount_7", write_count, 7);

    lcd_write(1'b0, 8'h90); wait_idle();
    chk("addr_err_lit", addr_err, 1);
    lcd_read(1'b0, v);
    chk("addr_kept", v, 8'h00);
    lcd_write(1'b0, 8'hCF); wait_idle();
    lcd_read(1'b0, v);
    chk("addr_4f", v, 8'h4F);
    lcd_write(1'b0, 8'hD0); wait_idle();
    lcd_read(1'b0, v);
    chk("addr_kept_d0", v, 8'h4F);
    lcd_write(1'b1, 8'h4D); wait_idle();
    expect_cell(31, 8'h4D, "cell_M");

    lcd_write(1'b0, 8'h01);
    expect_cell(0, 8'h20, "mid_clear_wiped");
    expect_cell(31, 8'h4D, "mid_clear_old");
    repeat (3) tick();
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_wcount", write_count, 0);
    chk("rst_disp", display_on, 0);
    expect_cell(31, 8'h20, "rst_cell31");
    lcd_read(1'b0, v);
    chk("rst_status", v, 8'h00);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
